pred_counter_table: RTL and testbench

- Branch-predictor history table: an array of 2-bit saturating counters indexed by a line address.
- Every clock edge the addressed counter is read, advanced by a saturating up/down FSM according to the actual outcome `p`, and written back.
- The current counter value is presented combinationally as the prediction state.
- Integrates the counter next-state logic (former fsm_table_cc role) and the storage array (former pred_table role) in one block.

---
 rtl/pred_counter_table.sv | 78 +++++++
 tb/tb_pred_counter_table.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pred_counter_table.sv
// Branch-predictor history table: 2**IDX_W two-bit saturating counters, read
// combinationally at the addressed line and stepped toward outcome p on every
// clock edge. Optional misprediction statistics are built when PRED_STATS_EN
// is defined.
`timescale 1ns/1ps
module pred_counter_table #(
  parameter int unsigned IDX_W     = 7,
  parameter logic [1:0]  RST_STATE = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] line,
  input  logic             p,
  output logic [1:0]       dout,
  output logic             taken
`ifdef PRED_STATS_EN
  ,
  output logic [15:0]      miss_cnt,
  output logic             miss
`endif
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_t;

  logic [1:0] entries [DEPTH];
  ctr_t       cur;
  ctr_t       nxt;

  always_comb begin
    cur = ctr_t'(entries[line]);
  end

  // Saturating step: toward STRONG_T on taken, toward STRONG_NT otherwise.
  always_comb begin
    nxt = cur;
    unique case (cur)
      STRONG_NT: nxt = p ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = p ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = p ? STRONG_T : WEAK_NT;
      STRONG_T:  nxt = p ? STRONG_T : WEAK_T;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries <= '{default: RST_STATE};
    end else begin
      entries[line] <= nxt;
    end
  end

  always_comb begin
    dout  = cur;
    taken = cur[1];
  end

`ifdef PRED_STATS_EN
  always_comb begin
    miss = taken != p;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_cnt <= '0;
    end else if (miss && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pred_counter_table.sv
// Self-checking bench for pred_counter_table: directed scenarios then random
// traffic against an array-of-integers reference model.
`timescale 1ns/1ps
module tb_pred_counter_table;

  localparam int unsigned IDX_W = 7;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic             clk;
  logic             reset;
  logic [IDX_W-1:0] line;
  logic             p;
  logic [1:0]       dout;
  logic             taken;
`ifdef PRED_STATS_EN
  logic [15:0]      miss_cnt;
  logic             miss;
  int               model_miss;
`endif

  int model [DEPTH];
  int checks;
  int errors;

  pred_counter_table #(
    .IDX_W    (IDX_W),
    .RST_STATE(2'b00)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .line    (line),
    .p       (p)
    ,
    .dout    (dout),
    .taken   (taken)
`ifdef PRED_STATS_EN
    ,
    .miss_cnt(miss_cnt),
    .miss    (miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 0;
`ifdef PRED_STATS_EN
    model_miss = 0;
`endif
  endtask

  // Drive one update, advance one edge, apply the counter rule to the model.
  task automatic step(input int l, input bit pv);
    line = l[IDX_W-1:0];
    p    = pv;
    @(posedge clk);
`ifdef PRED_STATS_EN
    if ((model[l] >= 2) != pv && model_miss < 65535) model_miss++;
`endif
    if (pv) model[l] = (model[l] == 3) ? 3 : model[l] + 1;
    else    model[l] = (model[l] == 0) ? 0 : model[l] - 1;
    #1;
  endtask

  task automatic check_cur(input string tag, input int l);
    check({tag, "_dout"},  16'(dout),  16'(model[l]));
    check({tag, "_taken"}, 16'(taken), 16'(model[l] >= 2));
  endtask

  task automatic check_line(input string tag, input int l);
    line = l[IDX_W-1:0];
    #1;
    check_cur(tag, l);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    line   = '0;
    p      = 1'b0;
    reset  = 1'b1;
    model_reset();
    #1;
    check_line("rst_l0", 0);
    reset = 1'b0;
    check_line("rst_l127", 127);

    // Underflow guard at strong not-taken.
    for (int k = 0; k < 5; k++) begin
      step(2, 1'b0);
      check_cur("sat_low", 2);
    end
`ifdef PRED_STATS_EN
    check("stats_after_nt", miss_cnt, 16'd0);
`endif

    // Climb: 1,2,3,3,3.
    for (int k = 0; k < 5; k++) begin
      step(2, 1'b1);
      check_cur("climb", 2);
`ifdef PRED_STATS_EN
      check("miss_cnt_climb", miss_cnt, 16'(model_miss));
`endif
    end
    check("climb_const", 16'(dout), 16'd3);

    // Descend: 2,1,0,0,0.
    for (int k = 0; k < 5; k++) begin
      step(2, 1'b0);
      check_cur("descend", 2);
    end
    check("descend_const", 16'(dout), 16'd0);

    // Isolation between entries.
    for (int k = 0; k < 3; k++) step(2, 1'b1);
    check_line("iso_l5", 5);
    check_line("iso_l2", 2);
    check("iso_const", 16'(dout), 16'd3);

    // Asynchronous reset between edges.
    reset = 1'b1;
    model_reset();
    #1;
    check_cur("async_rst", 2);
    #1;
    reset = 1'b0;
    step(2, 1'b1);
    check_cur("post_rst", 2);
    check("post_rst_const", 16'(dout), 16'd1);

    // Reset held across an edge: no write may land.
    reset = 1'b1;
    model_reset();
    line = 7'd2;
    p    = 1'b1;
    @(posedge clk);
    #1;
    check_cur("rst_edge", 2);
    reset = 1'b0;

`ifdef PRED_STATS_EN
    // Misprediction count from a fresh reset: 3 taken then 1 not-taken.
    for (int k = 0; k < 3; k++) step(2, 1'b1);
    check("stats_3t", miss_cnt, 16'd2);
    for (int k = 0; k < 3; k++) step(2, 1'b1);
    line = 7'd2;
    p    = 1'b0;
    #1;
    check("miss_comb", 16'(miss), 16'd1);
    step(2, 1'b0);
    check("stats_nt", miss_cnt, 16'd3);
`endif

    // Random traffic concentrated on a few lines to force saturation.
    for (int k = 0; k < 400; k++) begin
      int l;
      l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                      : int'($urandom_range(0, 7));
      step(l, 1'($urandom_range(0, 1)));
      check_cur("rand", l);
`ifdef PRED_STATS_EN
      check("rand_miss_cnt", miss_cnt, 16'(model_miss));
`endif
      if (k % 8 == 0) check_line("rand_probe", int'($urandom_range(0, DEPTH - 1)));
    end

    // Full sweep: read every entry before its own update.
    for (int i = 0; i < DEPTH; i++) begin
      check_line("sweep", i);
      step(i, 1'($urandom_range(0, 1)));
      check_cur("sweep_upd", i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
